// File: rtl/alu_wb_queue.sv
// Write-back queue between an ALU and the register file: buffers {result, rd}
// in FIFO order and keeps the architectural Z/C/O flags.
module alu_wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_S,
    input  logic                     in_Z,
    input  logic                     in_C,
    input  logic                     in_O,
    input  logic [4:0]               in_rd,
    input  logic                     in_fwe,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_S,
    output logic [4:0]               out_rd,
    output logic                     flag_Z,
    output logic                     flag_C,
    output logic                     flag_O,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [31:0]   s_mem [DEPTH];
    logic [4:0]    rd_mem [DEPTH];

    logic [AW-1:0] head_reg, head_next;
    logic [AW-1:0] tail_reg, tail_next;
    logic [AW:0]   count_reg, count_next;
    logic [31:0]   out_s_reg, out_s_next;
    logic [4:0]    out_rd_reg, out_rd_next;
    logic [2:0]    flag_reg;
    logic [2:0]    in_flags;
    logic          accept, push, pop;

    assign in_ready  = !rst && (count_reg < FULL);
    assign out_valid = (count_reg != '0);
    assign accept    = in_valid && in_ready;
    // Results targeting r0 never occupy an entry; they may still update flags.
    assign push      = accept && (in_rd != 5'd0);
    assign pop       = out_valid && out_ready;
    assign in_flags  = {in_Z, in_C, in_O};

    always_comb begin
        head_next   = head_reg;
        tail_next   = tail_reg;
        count_next  = count_reg;
        out_s_next  = 32'h0;
        out_rd_next = 5'h0;
        if (pop) begin
            head_next = head_reg + AW'(1);
        end
        if (push) begin
            tail_next = tail_reg + AW'(1);
        end
        count_next = count_reg + (AW+1)'(push) - (AW+1)'(pop);
        // Prefetch the next head into the output register; if that entry is
        // the one being written at this edge, take it from the input instead.
        if (count_next != '0) begin
            if (push && (head_next == tail_reg)) begin
                out_s_next  = in_S;
                out_rd_next = in_rd;
            end else begin
                out_s_next  = s_mem[head_next];
                out_rd_next = rd_mem[head_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            s_mem[tail_reg]  <= in_S;
            rd_mem[tail_reg] <= in_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg   <= '0;
            tail_reg   <= '0;
            count_reg  <= '0;
            out_s_reg  <= 32'h0;
            out_rd_reg <= 5'h0;
        end else begin
            head_reg   <= head_next;
            tail_reg   <= tail_next;
            count_reg  <= count_next;
            out_s_reg  <= out_s_next;
            out_rd_reg <= out_rd_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_flag
            always_ff @(posedge clk) begin
                if (rst) begin
                    flag_reg[gi] <= 1'b0;
                end else if (accept && in_fwe) begin
                    flag_reg[gi] <= in_flags[gi];
                end
            end
        end
    endgenerate

    assign out_S  = out_s_reg;
    assign out_rd = out_rd_reg;
    assign flag_Z = flag_reg[2];
    assign flag_C = flag_reg[1];
    assign flag_O = flag_reg[0];
    assign count  = count_reg;
endmodule

// File: doc/alu_wb_queue.md
ALU_WB_QUEUE -- requirements
Module: alu_wb_queue

Interface
REQ-001 Parameter: DEPTH, default 4, number of result entries held; SHALL be a power of two, 2 to 16.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in_valid  input  1  upstream ALU result present this cycle.
REQ-005 in_ready  output  1  queue can accept a result this cycle.
REQ-006 in_S  input  32  ALU result word.
REQ-007 in_Z, in_C, in_O  input  1 each  ALU zero, carry and overflow flags for in_S.
REQ-008 in_rd  input  5  destination register index.
REQ-009 in_fwe  input  1  flag-write enable for this result.
REQ-010 out_valid  output  1  head entry available for register-file write.
REQ-011 out_ready  input  1  register file consumes head entry this cycle.
REQ-012 out_S  output  32  head entry result word.
REQ-013 out_rd  output  5  head entry destination index.
REQ-014 flag_Z, flag_C, flag_O  output  1 each  architectural status flags.
REQ-015 count  output  log2(DEPTH)+1  number of occupied entries.

Function
REQ-016 Accept = in_valid && in_ready; pop = out_valid && out_ready; both evaluated at the same rising edge.
REQ-017 in_ready SHALL be 1 when count < DEPTH and rst = 0, else 0; in_ready SHALL NOT depend on out_ready or in_valid.
REQ-018 On accept with in_rd != 0, {in_S, in_rd} SHALL be written at the tail and the tail pointer advanced.
REQ-019 On accept with in_rd = 0, the result SHALL be discarded (no enqueue, count unchanged by it); flag update per REQ-021 still applies.
REQ-020 out_valid = (count != 0); out_S/out_rd SHALL show the head entry when out_valid = 1 and 32'h0/5'h0 when empty.
REQ-021 On accept with in_fwe = 1, flag_Z/C/O SHALL load in_Z/in_C/in_O at that edge; with in_fwe = 0 flags hold.
REQ-022 Latency: entry accepted at edge k SHALL appear at out_* with out_valid = 1 after edge k; no same-cycle bypass from in_* to out_*.
REQ-023 Order: entries SHALL leave in acceptance order (FIFO).
REQ-024 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor go below 0.
REQ-025 Simultaneous enqueue and pop: count unchanged, both pointers advance; legal for any count 1..DEPTH-1.
REQ-026 Full (count = DEPTH): in_ready = 0; pop at that edge makes in_ready = 1 the following cycle only.
REQ-027 Empty: out_ready ignored, pointers and count unchanged.
REQ-028 Accept with in_rd = 0 plus simultaneous pop: count decrements by 1.

Reset
REQ-029 While rst = 1 at an edge: count = 0, head/tail = 0, flag_Z/C/O = 0, out_valid = 0, out_S = 0, out_rd = 0.
REQ-030 While rst = 1: in_ready = 0; in_valid and out_ready SHALL be ignored.
REQ-031 Reset mid-operation SHALL discard all queued entries; contents of storage need not be cleared.
REQ-032 First accept possible at the first edge with rst = 0.

Verification
REQ-033 Reset then push {S=32'h0000_0005, rd=3, fwe=1, Z=0,C=1,O=0} -> next cycle out_valid=1, out_S=5, out_rd=3, flag_C=1, count=1.
REQ-034 DEPTH=4, out_ready=0, push 5 results rd=1..5 -> in_ready=0 after 4th accept, 5th held; count=4; drain yields rd 1,2,3,4 in order.
REQ-035 Push S=0, rd=0, fwe=1, Z=1 -> count stays 0, out_valid=0, flag_Z=1 next cycle.
REQ-036 count=2, push and pop same edge for 6 cycles with rd cycling 1..6 -> count stays 2, order preserved across pointer wrap.
REQ-037 Push fwe=1 Z=1, then fwe=0 Z=0,C=1 -> flags remain Z=1,C=0 after second accept.
REQ-038 count=3, assert rst one cycle with in_valid=1 -> count=0, out_valid=0, flags=0, in_ready=0 during rst, no entry accepted.
